// File: rtl/puf_pkg.sv
// Shared types and default widths for the PUF measurement datapath.
// The ro_freq_counter build option RO_CNT_SAT_EN lives in that module, not here.
package puf_pkg;

  localparam int RO_CNT_W = 16;
  localparam int RO_WIN_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COUNT,
    DONE
  } ro_cnt_state_t;

endpackage

// File: rtl/ro_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, plus a one-flop rising-edge detector.
// Reusable by any PUF stage that needs to count edges of a free-running signal.
module ro_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Rising edge: newest synchronized sample high, previous one low.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: enable, settle, count ro_in edges over a clk window, report.
// Build option RO_CNT_SAT_EN: edge counter saturates at all-ones instead of wrapping.
module ro_freq_counter
  import puf_pkg::*;
#(
  parameter int CNT_W       = RO_CNT_W,
  parameter int WIN_W       = RO_WIN_W,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] window,
  input  logic             ro_in,
  output logic             ro_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output ro_cnt_state_t    state_dbg
);

  // Handshake: start is accepted only in IDLE (busy=0); done is a single-cycle
  // pulse with count/overflow valid alongside it; start while busy is dropped.

  localparam logic [WIN_W-1:0] WIN_ONE     = WIN_W'(1);
  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  ro_cnt_state_t    state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             ro_en_q, ro_en_d;
  logic             ro_rise;

  ro_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(ro_in),
    .rise    (ro_rise)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    ro_en_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          ovf_d = 1'b0;
          cyc_d = '0;
          // A zero-length window reports immediately without waking the oscillator.
          if (window != '0) begin
            win_d   = window;
            state_d = SETTLE;
          end else begin
            state_d = DONE;
          end
        end
      end
      SETTLE: begin
        if (cyc_q == SETTLE_LAST) begin
          cyc_d   = '0;
          state_d = COUNT;
        end else begin
          cyc_d = cyc_q + WIN_ONE;
        end
      end
      COUNT: begin
        if (ro_rise) begin
`ifdef RO_CNT_SAT_EN
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_ONE;
`else
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
`endif
        end
        if (cyc_q == win_q - WIN_ONE) state_d = DONE;
        else                          cyc_d   = cyc_q + WIN_ONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Result register loads on entry to DONE so it is valid with the done pulse.
    if (state_d == DONE) count_d = cnt_d;
    ro_en_d = (state_d == SETTLE) || (state_d == COUNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      cyc_q   <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ro_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      ro_en_q <= ro_en_d;
    end
  end

  assign ro_enable = ro_en_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: a 16-bit and a 4-bit counter share stimulus and are
// checked every cycle against a timeline model; directed tests pin hand-computed values.
module tb_ro_freq_counter;
  import puf_pkg::*;

  localparam int SC = 4;
  localparam int SS = 2;

  // ---------------- clock / reset / stimulus signals ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] window = '0;
  logic        ro_in = 1'b0;

  logic          en16, busy16, done16, ovf16;
  logic [15:0]   cnt16;
  ro_cnt_state_t st16;
  logic          en4, busy4, done4, ovf4;
  logic [3:0]    cnt4;
  ro_cnt_state_t st4;

  always #5 clk = ~clk;

  ro_freq_counter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(SS), .SETTLE_CYC(SC)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .window(window), .ro_in(ro_in),
    .ro_enable(en16), .busy(busy16), .done(done16), .count(cnt16),
    .overflow(ovf16), .state_dbg(st16)
  );

  ro_freq_counter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(SS), .SETTLE_CYC(SC)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .window(window), .ro_in(ro_in),
    .ro_enable(en4), .busy(busy4), .done(done4), .count(cnt4),
    .overflow(ovf4), .state_dbg(st4)
  );

  // Oscillator stand-in: square wave of ro_period clk cycles, changing on negedge.
  int ro_period = 0;
  int ro_ph = 0;
  always @(negedge clk) begin
    if (ro_period < 2) begin
      ro_in = 1'b0;
    end else begin
      ro_ph = (ro_ph + 1) % ro_period;
      ro_in = (ro_ph < ro_period / 2);
    end
  end

  // ---------------- check bookkeeping ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- timeline model ----------------
  // A measurement accepted at posedge a: outputs after posedge a+e are busy for
  // e <= D, done at e == D, ro_enable for e < D (D = SC+W, or 0 when W == 0).
  // Counted edges: ro_in rises seen SS posedges late, over posedges a+SC+1..a+SC+W.
  int cyc = 0;
  bit r_hist [0:4095];
  bit m_act = 1'b0;
  int m_a = 0;
  int m_w = 0;
  int m_n = 0;

  function automatic int done_e(input int w);
    return (w == 0) ? 0 : SC + w;
  endfunction

  function automatic bit rise_at(input int j);
    if (j < 1) return 1'b0;
    return r_hist[j] && !r_hist[j-1];
  endfunction

  function automatic int exp_c4(input int n);
`ifdef RO_CNT_SAT_EN
    return (n > 15) ? 15 : n;
`else
    return n % 16;
`endif
  endfunction

  always @(posedge clk) begin
    int e;
    if (cyc < 4095) cyc++;
    r_hist[cyc] = rst_n ? ro_in : 1'b0;
    if (!rst_n) begin
      m_act = 1'b0;
    end else begin
      if (m_act) begin
        e = cyc - m_a;
        if (m_w != 0 && e >= SC + 1 && e <= SC + m_w && rise_at(cyc - SS)) m_n++;
        if (e >= done_e(m_w) + 2) m_act = 1'b0;
      end
      if (!m_act && start) begin
        m_act = 1'b1;
        m_a   = cyc;
        m_w   = int'(window);
        m_n   = 0;
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  logic [31:0] exp_q[$];
  always @(negedge clk) begin
    int e, de;
    bit xb, xd, xe;
    if (!rst_n) begin
      chk("rst_busy16", 32'(busy16), 0);
      chk("rst_en16",   32'(en16),   0);
      chk("rst_done16", 32'(done16), 0);
      chk("rst_cnt16",  32'(cnt16),  0);
      chk("rst_ovf16",  32'(ovf16),  0);
      chk("rst_state16", 32'(st16 == IDLE), 1);
      chk("rst_busy4",  32'(busy4),  0);
      chk("rst_en4",    32'(en4),    0);
      chk("rst_cnt4",   32'(cnt4),   0);
    end else begin
      xb = 1'b0; xd = 1'b0; xe = 1'b0;
      if (m_act) begin
        e  = cyc - m_a;
        de = done_e(m_w);
        xb = (e <= de);
        xd = (e == de);
        xe = (m_w != 0) && (e < de);
      end
      chk("busy16",  32'(busy16), 32'(xb));
      chk("done16",  32'(done16), 32'(xd));
      chk("en16",    32'(en16),   32'(xe));
      chk("state16_done", 32'(st16 == DONE), 32'(xd));
      chk("busy4",   32'(busy4),  32'(xb));
      chk("done4",   32'(done4),  32'(xd));
      chk("en4",     32'(en4),    32'(xe));
      chk("state4_idle", 32'(st4 == IDLE), 32'(!xb));
      if (xd) begin
        exp_q.push_back(32'(m_n % 65536));
        exp_q.push_back(32'(m_n > 65535));
        exp_q.push_back(32'(exp_c4(m_n)));
        exp_q.push_back(32'(m_n > 15));
        chk("count16",    32'(cnt16), exp_q.pop_front());
        chk("overflow16", 32'(ovf16), exp_q.pop_front());
        chk("count4",     32'(cnt4),  exp_q.pop_front());
        chk("overflow4",  32'(ovf4),  exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one start and wait (bounded) for done; n = cycles from the start cycle.
  task automatic run_one(input int w, input int budget, output int n, output int en_n);
    @(negedge clk);
    start  = 1'b1;
    window = 16'(w);
    @(negedge clk);
    start = 1'b0;
    n     = 1;
    en_n  = 0;
    while (!done16 && n < budget) begin
      if (en16) en_n++;
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", 32'(done16), 1);
  endtask

  task automatic set_ro(input int period);
    ro_period = period;
    repeat (12) @(negedge clk);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n, en_n, pulses, c, k, t;
    int tt[3];
    int cc[3];

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // T1: period 10, window 100 -> 10 edges, done 105 cycles after start.
    set_ro(10);
    run_one(100, 200, n, en_n);
    chk("t1_latency",   32'(n), 105);
    chk("t1_en_cycles", 32'(en_n), 104);
    chk("t1_en_at_done", 32'(en16), 0);
    chk("t1_count16",   32'(cnt16), 10);
    chk("t1_ovf16",     32'(ovf16), 0);
    chk("t1_count4",    32'(cnt4), 10);

    // T2: zero window -> done next cycle, count 0, oscillator never enabled.
    run_one(0, 10, n, en_n);
    chk("t2_latency",   32'(n), 1);
    chk("t2_en_cycles", 32'(en_n), 0);
    chk("t2_count16",   32'(cnt16), 0);

    // T3: period 4, window 80 -> 20 edges; the 4-bit instance overflows.
    set_ro(4);
    run_one(80, 200, n, en_n);
    chk("t3_latency", 32'(n), 85);
    chk("t3_count16", 32'(cnt16), 20);
    chk("t3_ovf16",   32'(ovf16), 0);
`ifdef RO_CNT_SAT_EN
    chk("t3_count4", 32'(cnt4), 15);
`else
    chk("t3_count4", 32'(cnt4), 4);
`endif
    chk("t3_ovf4", 32'(ovf4), 1);

    // T4: second start during COUNT is ignored.
    set_ro(10);
    @(negedge clk);
    start = 1'b1; window = 16'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    start = 1'b1; window = 16'd7;
    @(negedge clk);
    start = 1'b0; window = 16'd50;
    pulses = 0; c = -1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done16) begin
        pulses++;
        c = int'(cnt16);
      end
    end
    chk("t4_done_pulses", 32'(pulses), 1);
    chk("t4_count16",     32'(c), 5);

    // T5: asynchronous reset mid-COUNT, then a clean measurement.
    set_ro(6);
    @(negedge clk);
    start = 1'b1; window = 16'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_busy_before_rst", 32'(busy16), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_async_en16",   32'(en16), 0);
    chk("t5_async_busy16", 32'(busy16), 0);
    chk("t5_async_cnt16",  32'(cnt16), 0);
    chk("t5_async_done16", 32'(done16), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_ro(6);
    run_one(30, 100, n, en_n);
    chk("t5_latency",  32'(n), 35);
    chk("t5_count16",  32'(cnt16), 5);

    // T6: start held high -> done every 26 cycles, 2..3 edges per window.
    set_ro(8);
    @(negedge clk);
    start = 1'b1; window = 16'd20;
    k = 0; t = 0;
    while (k < 3 && t < 120) begin
      @(negedge clk);
      t++;
      if (done16) begin
        tt[k] = t;
        cc[k] = int'(cnt16);
        k++;
      end
    end
    start = 1'b0;
    chk("t6_pulses",     32'(k), 3);
    chk("t6_first_done", 32'(tt[0]), 25);
    chk("t6_spacing_a",  32'(tt[1] - tt[0]), 26);
    chk("t6_spacing_b",  32'(tt[2] - tt[1]), 26);
    for (int i = 0; i < 3; i++)
      chk("t6_count_range", 32'(cc[i] >= 2 && cc[i] <= 3), 1);
    repeat (3) @(negedge clk);
    chk("t6_idle_after", 32'(busy16), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
Measurement stage directly downstream of ring_osc in the PUF datapath. On each start request it drives the oscillator's enable high, waits a settle period, and counts rising edges of the oscillator output over a programmable window of clk cycles. It then reports the count with a done pulse. The PUF response logic consumes the count by comparing count pairs between oscillators.

Parameters:
- CNT_W, 16: edge-counter and count output width.
- WIN_W, 16: width of the window length input.
- SYNC_STAGES, 2: flops in the ro_in synchronizer, minimum 2.
- SETTLE_CYC, 4: clk cycles between asserting ro_enable and opening the count window, minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  measurement request, sampled in IDLE only.
- window  in  WIN_W  count window length in clk cycles, captured on accepted start.
- ro_in  in  1  oscillator output, asynchronous to clk.
- ro_enable  out  1  drives ring_osc enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when count is valid.
- count  out  CNT_W  result, held until the next accepted start.
- overflow  out  1  counter wrapped (or saturated) during the last window.

Behaviour:
- Clock and reset: single clk domain; rst_n is asynchronous assert, active low.
- Reset values: ro_enable=0, busy=0, done=0, count=0, overflow=0, FSM=IDLE, synchronizer flops=0.
- ro_in passes through SYNC_STAGES flops, then one extra flop for edge detect. A rising edge is sync_last=1 and sync_prev=0.
- Valid measurement requires f_ro < f_clk/2. Faster oscillators alias; this is documented, not detected.

FSM states and transitions:
- IDLE: start=1 with window!=0 -> SETTLE. Captures window into win_q, clears the edge counter and overflow, asserts ro_enable. start with window==0 -> DONE directly with count=0 and ro_enable kept 0.
- SETTLE: counts SETTLE_CYC cycles, then -> COUNT. Edges during SETTLE are ignored; edge detect stays armed so that startup glitches are flushed.
- COUNT: runs exactly win_q cycles. Each detected edge increments the counter. On the last cycle -> DONE. An edge detected on the final COUNT cycle is included.
- DONE: ro_enable=0, count<=counter, done=1 for exactly this one cycle, then -> IDLE.
- Latency: start accepted to done = 1 + SETTLE_CYC + win_q cycles.

Boundary conditions:
- start while busy is ignored, with no queueing.
- Counter wrap: if the increment is taken at all-ones, the counter wraps to 0 and overflow is set, sticky for the window.
- Async reset mid-measurement drops ro_enable in the same instant, with no done pulse.
- start held high continuously produces back-to-back measurements, with one IDLE cycle between them.

Optional Feature:
- Macro: RO_CNT_SAT_EN.
- Defined: the counter saturates at 2^CNT_W-1 instead of wrapping. overflow is still set on the first attempted increment past max.
- Undefined: the counter wraps modulo 2^CNT_W and overflow is set.

Decomposition:
- Package puf_pkg holds:
  - the FSM state enum ro_cnt_state_t (IDLE, SETTLE, COUNT, DONE);
  - the default width constants RO_CNT_W and RO_WIN_W.
- Sub-module ro_sync_edge holds the SYNC_STAGES synchronizer plus rising-edge detector, and is reusable by other PUF stages.
- The counter and FSM stay in ro_freq_counter.

Test Plan:
1. Model ro_in as a period-10 clk square wave, window=100, SETTLE_CYC=4. Required: done exactly 105 cycles after the start cycle, count=10, overflow=0, ro_enable high for cycles 1..104 after start.
2. start with window=0. Required: done on the next cycle, count=0, ro_enable never asserts.
3. CNT_W=4, ro_in period 4, window=80 (20 edges). Required: without the macro, count=4 and overflow=1. With RO_CNT_SAT_EN, count=15 and overflow=1.
4. Pulse start again during COUNT of a window=50 run. Required: ignored, a single done pulse only, count reflects the original run.
5. Drop rst_n mid-COUNT. Required: ro_enable, busy and count go 0 asynchronously, there is no done pulse, and a subsequent start measures correctly.
6. Hold start high with window=20 and ro_in period 8. Required: repeated done pulses every 26 cycles (25 + 1 IDLE), each with count in 2..3 (window-phase dependent).
